// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: FSM states, round constants and the
// GF(2^8) arithmetic used by InvMixColumns.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [3:0] round_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (the InvMixColumns coefficients 9, b, d, e)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul = (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Handshake and round-key bus of the AES-128 inverse cipher.
interface aes_inv_cipher_if;
  import aes_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  round_idx_t   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  modport master (
    output in_valid, ciphertext, rk, out_ready,
    input  in_ready, rk_idx, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, rk, out_ready,
    output in_ready, rk_idx, out_valid, plaintext
  );

endinterface

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box as a 256-entry constant table, purely combinational.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 sits in the top byte, so entry a starts at bit 8*(255-a)
  assign y = TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched
// from an external key store through rk_idx/rk.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output round_idx_t   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  state_t       state;
  state_t       state_next;
  round_idx_t   count;
  logic [127:0] blk;
  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8]
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[127-8*(4*c+r) -: 8] = blk[127-8*(4*((c+4-r)%4)+r) -: 8];
      inv_sbox u_sbox (
        .a (shifted[127-8*(4*c+r) -: 8]),
        .y (subbed[127-8*(4*c+r) -: 8])
      );
    end
  end

  assign keyed = subbed ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    assign a0 = keyed[127-32*c -: 8];
    assign a1 = keyed[119-32*c -: 8];
    assign a2 = keyed[111-32*c -: 8];
    assign a3 = keyed[103-32*c -: 8];
    assign mixed[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
    assign mixed[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
    assign mixed[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
    assign mixed[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Round counter, working state and plaintext output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= 4'd0;
      blk       <= 128'd0;
      plaintext <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            blk   <= ciphertext ^ rk;
            count <= round_idx_t'(NR - 1);
          end
        end
        ROUND: begin
          blk   <= mixed;
          count <= count - 4'd1;
        end
        LAST:    plaintext <= keyed;
        default: ;
      endcase
    end
  end

  // Next-state and handshake/key-index decode; rk_idx never depends on in_valid
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rk_idx     = round_idx_t'(NR);
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          state_next = ROUND;
        end else begin
          state_next = IDLE;
        end
      end
      ROUND: begin
        rk_idx = count;
        if (count == 4'd1) begin
          state_next = LAST;
        end else begin
          state_next = ROUND;
        end
      end
      LAST: begin
        rk_idx     = 4'd0;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
